fifo_wr_arbiter: RTL and testbench

//   Round-robin write arbiter that shares one fifo write port among NUM_REQ

---
 rtl/fifo_wr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//   This block lets NUM_REQ valid/ready requesters share one fifo write port.
//   It uses round-robin arbitration. Each grant is a burst of up to MAX_BURST
//   words, and then priority rotates to the next requester. Every IDLE->GRANT
//   hop costs one arbitration bubble.
//
//   The transfer handshake (fifo_wrreq_o, req_ready_o, fifo_data_o) is
//   combinational from the registered owner and the live valid/full inputs.
//   Because of this, a full fifo stalls the burst with zero latency. An
//   asserted arst_i drops everything at once.
//
//   Optional feature: define FIFO_ARB_WATERMARK_EN so that no new burst is
//   granted while fifo_almost_full_i is high. A burst that is already running
//   is still gated only by fifo_full_i. Without the macro, fifo_almost_full_i
//   is ignored.
// ----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DWIDTH-1:0]         fifo_data_o,
  output logic                      fifo_wrreq_o,
  input  logic                      fifo_full_i,
  input  logic                      fifo_almost_full_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Registered arbitration state
  state_t              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                busy_q;
  logic [PW-1:0]       own_q;
  logic [PW-1:0]       rr_ptr_q;
  logic [CW-1:0]       beat_cnt_q;

  // Combinational helpers
  logic [PW-1:0]       rr_ptr_d;
  logic [PW-1:0]       pick_idx_s;
  logic                pick_found_s;
  logic                start_s;
  logic                own_valid_s;
  logic                xfer_s;
  logic                burst_last_s;
  logic [DWIDTH-1:0]   req_word_s [NUM_REQ];

  // One-hot encoding of a requester index
  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_REQ-1:0] ret;
    ret      = '0;
    ret[idx] = 1'b1;
    return ret;
  endfunction

  // Split the flat data bus into one word per requester
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign req_word_s[g] = req_data_i[g*DWIDTH +: DWIDTH];
  end

  // Pick the first valid requester at or above rr_ptr, wrapping around.
  // The scan runs downward, so the candidate nearest rr_ptr is written last
  // and therefore wins.
  always_comb begin
    int cand;
    cand         = 0;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (req_valid_i[cand]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = PW'(cand);
      end else begin
        pick_found_s = pick_found_s;
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // The next round-robin start point is the requester after the current owner
  always_comb begin
    if (own_q == PW'(NUM_REQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = own_q + PW'(1);
    end
  end

`ifdef FIFO_ARB_WATERMARK_EN
  assign start_s = pick_found_s & ~fifo_almost_full_i;
`else
  logic unused_almost_full_s;
  assign unused_almost_full_s = fifo_almost_full_i;
  assign start_s = pick_found_s;
`endif

  // A word moves only while granted, the owner has data, and the fifo has room
  assign own_valid_s  = req_valid_i[own_q];
  assign xfer_s       = (state_q == ST_GRANT) & own_valid_s & ~fifo_full_i;
  assign burst_last_s = (beat_cnt_q == CW'(MAX_BURST - 1));

  assign fifo_wrreq_o = xfer_s;
  assign req_ready_o  = xfer_s ? grant_q : '0;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;

  // Drive the owner's word onto the fifo bus while granted, and zeros otherwise
  always_comb begin
    if (state_q == ST_GRANT) begin
      fifo_data_o = req_word_s[own_q];
    end else begin
      fifo_data_o = '0;
    end
  end

  // Arbitration FSM: grant on IDLE, count beats and release on GRANT
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      own_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q    <= ST_GRANT;
            own_q      <= pick_idx_s;
            grant_q    <= onehot(pick_idx_s);
            busy_q     <= 1'b1;
            beat_cnt_q <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (!own_valid_s) begin
            // Owner went away: close the burst without moving a word.
            // This check is ahead of the full check, so a valid drop wins.
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= rr_ptr_d;
          end else if (xfer_s) begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
            if (burst_last_s) begin
              state_q  <= ST_IDLE;
              grant_q  <= '0;
              busy_q   <= 1'b0;
              rr_ptr_q <= rr_ptr_d;
            end else begin
              state_q <= ST_GRANT;
            end
          end else begin
            // The fifo is full: hold the grant and the beat count
            state_q <= ST_GRANT;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          grant_q    <= '0;
          busy_q     <= 1'b0;
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   This bench drives randomized and patterned requester and fifo activity.
//   A reference model describes the arbiter as an owner number (-1 when
//   idle), a burst word count and a "first to ask" pointer. Every cycle the
//   bench compares the DUT outputs against that model.
//   Each requester's data word is {id, sequence number}, so the checks also
//   confirm that words arrive in order.
//   Honours FIFO_ARB_WATERMARK_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MB = 8;

`ifdef FIFO_ARB_WATERMARK_EN
  localparam bit WM_EN = 1'b1;
`else
  localparam bit WM_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             arst;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    fifo_data;
  logic             fifo_wrreq;
  logic             fifo_full;
  logic             fifo_af;
  logic [NR-1:0]    grant;
  logic             busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  // Reference model state
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int seq [NR];

  fifo_wr_arbiter #(.DWIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk_i              (clk),
    .arst_i             (arst),
    .req_data_i         (req_data),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .fifo_data_o        (fifo_data),
    .fifo_wrreq_o       (fifo_wrreq),
    .fifo_full_i        (fifo_full),
    .fifo_almost_full_i (fifo_af),
    .grant_o            (grant),
    .busy_o             (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int id);
    return {8'(id), 24'(seq[id])};
  endfunction

  // Drive the inputs for one cycle according to the traffic mode
  task automatic drive(input int mode);
    case (mode)
      0: begin req_valid = 4'b0010; fifo_full = 1'b0; fifo_af = 1'b0; end
      1: begin req_valid = 4'b1111; fifo_full = 1'b0; fifo_af = 1'b0; end
      2: begin
        for (int i = 0; i < NR; i++) req_valid[i] = ($urandom_range(0, 9) < 7);
        fifo_full = ($urandom_range(0, 4) == 0);
        fifo_af   = ($urandom_range(0, 3) == 0);
      end
      3: begin
        req_valid = 4'b1111;
        fifo_full = ((cyc % 13) >= 4) && ((cyc % 13) < 9);
        fifo_af   = 1'b0;
      end
      4: begin req_valid = 4'b1111; fifo_full = 1'b0; fifo_af = 1'b1; end
      default: begin req_valid = '0; fifo_full = 1'b0; fifo_af = 1'b0; end
    endcase
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_of(i);
  endtask

  // One cycle: drive the inputs, compare on the falling edge, then advance the model
  task automatic step(input int mode);
    logic [NR-1:0] exp_grant;
    logic          exp_xfer;
    logic [DW-1:0] exp_data;
    drive(mode);
    @(negedge clk);
    exp_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    exp_xfer  = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
    exp_data  = (m_owner >= 0) ? word_of(m_owner) : '0;
    check_eq("grant", 64'(grant), 64'(exp_grant));
    check_eq("busy", 64'(busy), 64'(m_owner >= 0));
    check_eq("wrreq", 64'(fifo_wrreq), 64'(exp_xfer));
    check_eq("ready", 64'(req_ready), 64'(exp_xfer ? exp_grant : 4'b0000));
    check_eq("data", 64'(fifo_data), 64'(exp_data));
    if (m_owner < 0) begin
      if (req_valid != '0 && !(WM_EN && fifo_af)) begin
        for (int k = NR - 1; k >= 0; k--)
          if (req_valid[(m_ptr + k) % NR]) m_owner = (m_ptr + k) % NR;
        m_beats = 0;
      end
    end else if (!req_valid[m_owner]) begin
      m_ptr   = (m_owner + 1) % NR;
      m_owner = -1;
    end else if (exp_xfer) begin
      seq[m_owner]++;
      m_beats++;
      if (m_beats == MB) begin
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) step(mode);
  endtask

  initial begin
    int tries;
    for (int i = 0; i < NR; i++) seq[i] = 100 * i;
    arst      = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    fifo_af   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_wrreq", 64'(fifo_wrreq), 64'd0);
    check_eq("rst_data", 64'(fifo_data), 64'd0);
    arst = 1'b0;

    run(30, 0);    // a single requester streams bursts of 8 with bubbles between them
    run(50, 1);    // all requesters valid: grants rotate 0,1,2,3
    run(60, 3);    // periodic full stalls in the middle of bursts
    run(300, 2);   // random valid, full and almost-full

    // Assert reset in the middle of a burst; the outputs must drop without waiting for a clock
    tries = 0;
    while (!(m_owner >= 0 && m_beats >= 2) && tries < 40) begin
      step(1);
      tries++;
    end
    check_eq("reach_burst", 64'(m_owner >= 0 && m_beats >= 2), 64'd1);
    #2;
    arst = 1'b1;
    #1;
    check_eq("arst_grant", 64'(grant), 64'd0);
    check_eq("arst_wrreq", 64'(fifo_wrreq), 64'd0);
    check_eq("arst_ready", 64'(req_ready), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 0;
    @(posedge clk);
    #1;
    arst = 1'b0;
    run(3, 1);     // after reset the first grant must go to requester 0

    run(20, 4);    // almost-full held high while idle
    run(300, 2);
    run(10, 5);    // drain to idle

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
